// File: rtl/i2s_slave_transmitter.sv
// PCM-to-I2S serializer slaved to an external bclk/lrclk, with a stereo frame FIFO.
// Build option I2S_TX_LJ_EN: left-justified output (MSB at the boundary, no one-bit delay).
module i2s_slave_transmitter #(
    parameter int DATA_W      = 24,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          bclk_in,
    input  logic                          lrclk_in,
    input  logic                          l_data_en,
    input  logic                          r_data_en,
    input  logic [DATA_W-1:0]             l_data,
    input  logic [DATA_W-1:0]             r_data,
    output logic                          s_data,
    output logic                          frame_stb,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    underrun_cnt,
    output logic                          overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_SYNC, ACTIVE} state_t;

    state_t                    state_q, state_d;
    logic [SYNC_STAGES-1:0]    bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0]    lr_sync_q, lr_sync_d;
    logic                      bclk_last_q, bclk_last_d;
    logic                      lr_last_q, lr_last_d;
    logic                      run_last_q, run_last_d;
    logic                      s_data_q, s_data_d;
    logic                      frame_stb_q, frame_stb_d;
    logic [DATA_W-1:0]         shift_q, shift_d;
    logic [2*DATA_W-1:0]       frame_q, frame_d;
    logic [DATA_W-1:0]         l_hold_q, l_hold_d;
    logic [7:0]                underrun_q, underrun_d;
    logic                      overflow_q, overflow_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]          level_q, level_d;
    logic [2*DATA_W-1:0]       fifo_mem_q [FIFO_DEPTH];

    logic                      fall_det, lr_sync, left_bnd, right_bnd;
    logic                      load_left, load_right, push_ok, pop;
    logic [DATA_W-1:0]         word;
    logic [2*DATA_W-1:0]       push_data;

    always_comb begin
        bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], bclk_in};
        lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], lrclk_in};
        bclk_last_d = bclk_sync_q[SYNC_STAGES-1];
        fall_det    = bclk_last_q & ~bclk_sync_q[SYNC_STAGES-1];
        lr_sync     = lr_sync_q[SYNC_STAGES-1];
        left_bnd    = fall_det & ~lr_sync & lr_last_q;
        right_bnd   = fall_det & lr_sync & ~lr_last_q;
        lr_last_d   = fall_det ? lr_sync : lr_last_q;
        run_last_d  = run;

        state_d     = state_q;
        s_data_d    = s_data_q;
        shift_d     = shift_q;
        frame_d     = frame_q;
        frame_stb_d = 1'b0;
        underrun_d  = underrun_q;
        overflow_d  = overflow_q;
        l_hold_d    = l_hold_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        push_ok     = 1'b0;
        pop         = 1'b0;
        load_left   = 1'b0;
        load_right  = 1'b0;
        word        = '0;
        push_data   = {(l_data_en ? l_data : l_hold_q), r_data};

        if (!run) begin
            state_d  = IDLE;
            s_data_d = 1'b0;
            shift_d  = '0;
            frame_d  = '0;
            l_hold_d = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (!run_last_q) overflow_d = 1'b0;
            if (l_data_en) l_hold_d = l_data;

            case (state_q)
                IDLE: begin
                    state_d  = WAIT_SYNC;
                    s_data_d = 1'b0;
                end
                WAIT_SYNC: begin
                    s_data_d = 1'b0;
                    if (left_bnd) begin
                        state_d   = ACTIVE;
                        load_left = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (left_bnd) begin
                        load_left = 1'b1;
                    end else if (right_bnd) begin
                        load_right = 1'b1;
                    end else if (fall_det) begin
                        s_data_d = shift_q[DATA_W-1];
                        shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                    end
                end
                default: state_d = IDLE;
            endcase

            if (load_left) begin
                if (level_q != '0) begin
                    pop         = 1'b1;
                    frame_d     = fifo_mem_q[rd_ptr_q];
                    frame_stb_d = 1'b1;
                end else begin
                    frame_d = '0;
                    if (underrun_q != 8'hFF) underrun_d = underrun_q + 8'd1;
                end
                word = frame_d[2*DATA_W-1:DATA_W];
            end else if (load_right) begin
                word = frame_q[DATA_W-1:0];
            end

            if (load_left || load_right) begin
`ifdef I2S_TX_LJ_EN
                s_data_d = word[DATA_W-1];
                shift_d  = {word[DATA_W-2:0], 1'b0};
`else
                s_data_d = 1'b0;
                shift_d  = word;
`endif
            end

            // a pop in the same cycle frees the slot, so a push while full is still taken
            if (r_data_en) begin
                if (level_q != FULL_LVL || pop) push_ok = 1'b1;
                else                            overflow_d = 1'b1;
            end
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            bclk_last_q <= 1'b0;
            lr_last_q   <= 1'b0;
            run_last_q  <= 1'b0;
            s_data_q    <= 1'b0;
            frame_stb_q <= 1'b0;
            shift_q     <= '0;
            frame_q     <= '0;
            l_hold_q    <= '0;
            underrun_q  <= '0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            bclk_sync_q <= bclk_sync_d;
            lr_sync_q   <= lr_sync_d;
            bclk_last_q <= bclk_last_d;
            lr_last_q   <= lr_last_d;
            run_last_q  <= run_last_d;
            s_data_q    <= s_data_d;
            frame_stb_q <= frame_stb_d;
            shift_q     <= shift_d;
            frame_q     <= frame_d;
            l_hold_q    <= l_hold_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem_q[wr_ptr_q] <= push_data;
    end

    assign s_data       = s_data_q;
    assign frame_stb    = frame_stb_q;
    assign fifo_level   = level_q;
    assign underrun_cnt = underrun_q;
    assign overflow     = overflow_q;
endmodule

// File: tb/tb_i2s_slave_transmitter.sv
// Directed bench for i2s_slave_transmitter: reset, nominal, strobes, overflow, underrun, run drop.
module tb_i2s_slave_transmitter;
    localparam int DATA_W      = 24;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        reset, run, bclk_in, lrclk_in, l_data_en, r_data_en;
    logic [23:0] l_data, r_data;
    logic        s_data, frame_stb, overflow;
    logic [2:0]  fifo_level;
    logic [7:0]  underrun_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int stb_cnt  = 0;
    int half     = 4;

    i2s_slave_transmitter #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .bclk_in(bclk_in), .lrclk_in(lrclk_in),
        .l_data_en(l_data_en), .r_data_en(r_data_en), .l_data(l_data), .r_data(r_data),
        .s_data(s_data), .frame_stb(frame_stb), .fifo_level(fifo_level),
        .underrun_cnt(underrun_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_stb) stb_cnt <= stb_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_slot(input logic [23:0] w);
`ifdef I2S_TX_LJ_EN
        return {w, 8'h00};
`else
        return {1'b0, w, 7'h00};
`endif
    endfunction

    // One bclk period: falling edge (with lrclk change), low then high phase; sample at the end.
    task automatic bit_cycle(input logic lr, output logic sb);
        bclk_in  = 1'b0;
        lrclk_in = lr;
        repeat (half) @(negedge clk);
        bclk_in = 1'b1;
        repeat (half) @(negedge clk);
        sb = s_data;
    endtask

    task automatic slot(input logic lr, input int nbits, output logic [31:0] v);
        logic b;
        v = '0;
        for (int i = 0; i < nbits; i++) begin
            bit_cycle(lr, b);
            if (i < 32) v[31-i] = b;
        end
    endtask

    task automatic frame(input int nbits, output logic [31:0] lv, output logic [31:0] rv);
        slot(1'b0, nbits / 2, lv);
        slot(1'b1, nbits / 2, rv);
    endtask

    task automatic push_frame(input logic [23:0] lw, input logic [23:0] rw);
        l_data_en = 1'b1;
        l_data    = lw;
        @(negedge clk);
        l_data_en = 1'b0;
        r_data_en = 1'b1;
        r_data    = rw;
        @(negedge clk);
        r_data_en = 1'b0;
    endtask

    initial begin
        logic [31:0] lv, rv, acc;
        logic [23:0] lw;
        logic        b;
        int          base;

        reset = 1'b1; run = 1'b0; bclk_in = 1'b1; lrclk_in = 1'b1;
        l_data_en = 1'b0; r_data_en = 1'b0; l_data = '0; r_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        run   = 1'b1;
        @(negedge clk);

        // reset with traffic active
        for (int k = 1; k <= 5; k++) push_frame(24'(24'h010101 * 24'(k)), 24'h00FF00);
        check("pre_reset_level", fifo_level, 4);
        check("pre_reset_ovf", overflow, 1);
        bit_cycle(1'b1, b); bit_cycle(1'b1, b);
        bit_cycle(1'b0, b); bit_cycle(1'b0, b); bit_cycle(1'b0, b);
        check("pre_reset_pop_level", fifo_level, 3);
        reset = 1'b1;
        @(negedge clk);
        check("rst_sdata", s_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_underrun", underrun_cnt, 0);
        check("rst_ovf", overflow, 0);
        check("rst_stb", frame_stb, 0);
        reset = 1'b0;
        @(negedge clk);

        // nominal 64fs frame
        push_frame(24'hA5A5A5, 24'h5A5A5A);
        check("nom_level_in", fifo_level, 1);
        base = stb_cnt;
        for (int i = 0; i < 4; i++) bit_cycle(1'b1, b);
        frame(64, lv, rv);
        check("nom_left", lv, exp_slot(24'hA5A5A5));
        check("nom_right", rv, exp_slot(24'h5A5A5A));
        check("nom_stb", stb_cnt - base, 1);
        check("nom_level_out", fifo_level, 0);
        check("nom_underrun", underrun_cnt, 0);

        // simultaneous strobes
        l_data_en = 1'b1; r_data_en = 1'b1; l_data = 24'h800000; r_data = 24'h7FFFFF;
        @(negedge clk);
        l_data_en = 1'b0; r_data_en = 1'b0;
        frame(64, lv, rv);
        check("sim_left", lv, exp_slot(24'h800000));
        check("sim_right", rv, exp_slot(24'h7FFFFF));
        check("sim_stb", stb_cnt - base, 2);

        // overflow with bclk stopped
        for (int k = 1; k <= 5; k++) begin
            lw = 24'(24'h111111 * 24'(k));
            push_frame(lw, ~lw);
        end
        check("ovf_level", fifo_level, 4);
        check("ovf_flag", overflow, 1);
        for (int k = 1; k <= 4; k++) begin
            lw = 24'(24'h111111 * 24'(k));
            frame(64, lv, rv);
            check("ovf_left", lv, exp_slot(lw));
            check("ovf_right", rv, exp_slot(~lw));
        end
        frame(64, lv, rv);
        check("ovf_5th_left", lv, 0);
        check("ovf_5th_right", rv, 0);
        check("ovf_underrun", underrun_cnt, 1);

        // underrun saturation at 50fs
        half = 2;
        acc  = '0;
        for (int k = 1; k <= 259; k++) begin
            frame(50, lv, rv);
            acc = acc | lv | rv;
            if (k == 100) check("und_100", underrun_cnt, 101);
            if (k == 254) check("und_254", underrun_cnt, 255);
        end
        check("und_silence", acc, 0);
        check("und_sat", underrun_cnt, 255);

        // run drop during left bit 10
        half = 4;
        push_frame(24'hFFFFFF, 24'h000001);
        push_frame(24'hABCDEF, 24'h123456);
        check("drop_level_in", fifo_level, 2);
        for (int i = 0; i <= 10; i++) bit_cycle(1'b0, b);
        check("drop_bit10", b, 1);
        check("drop_level_pop", fifo_level, 1);
        for (int k = 0; k < 4; k++) push_frame(24'h0F0F0F, 24'hF0F0F0);
        check("drop_full", fifo_level, 4);
        check("drop_ovf_set", overflow, 1);
        run = 1'b0;
        @(negedge clk);
        check("drop_sdata", s_data, 0);
        check("drop_level", fifo_level, 0);
        check("drop_ovf_hold", overflow, 1);
        run = 1'b1;
        @(negedge clk);
        check("rerun_ovf_clr", overflow, 0);
        push_frame(24'hC0FFEE, 24'h00BEEF);
        check("rerun_level", fifo_level, 1);
        base = stb_cnt;
        slot(1'b0, 21, lv);
        slot(1'b1, 32, rv);
        check("rerun_silence", lv | rv, 0);
        check("rerun_no_stb", stb_cnt - base, 0);
        frame(64, lv, rv);
        check("rerun_left", lv, exp_slot(24'hC0FFEE));
        check("rerun_right", rv, exp_slot(24'h00BEEF));
        check("rerun_stb", stb_cnt - base, 1);
        check("rerun_underrun", underrun_cnt, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
